// File: rtl/display_pkg.sv
// Shared constants and the debounce FSM state type for the hex-display source stage.
package display_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
  localparam int CNT_W_DEFAULT           = 20;
  localparam int DISP_W                  = 16;

  typedef enum logic [1:0] {
    DB_LOW  = 2'd0,
    DB_RISE = 2'd1,
    DB_HIGH = 2'd2,
    DB_FALL = 2'd3
  } db_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchroniser, then either the debounce FSM (BTN_DEBOUNCE_EN
// defined) or a plain rising-edge detector on the synchronised level (macro undefined).
//
// state   | meaning
// DB_LOW  | button accepted as released
// DB_RISE | synchronised level high, counting stable samples toward a press
// DB_HIGH | button accepted as pressed
// DB_FALL | synchronised level low, counting stable samples toward a release
module btn_debounce
  import display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press_pulse
);

  logic sync_a;
  logic sync_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  db_state_t        db_state;
  db_state_t        db_state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      db_state <= DB_LOW;
      cnt      <= '0;
    end else begin
      db_state <= db_state_next;
      cnt      <= cnt_next;
    end
  end

  // Every state change clears the counter, so it can never pass CNT_LAST.
  always_comb begin
    db_state_next = db_state;
    cnt_next      = cnt;
    press_pulse   = 1'b0;
    case (db_state)
      DB_LOW: begin
        if (sync_b) begin
          db_state_next = DB_RISE;
          cnt_next      = '0;
        end
      end
      DB_RISE: begin
        if (!sync_b) begin
          db_state_next = DB_LOW;
          cnt_next      = '0;
        end else if (cnt == CNT_LAST) begin
          db_state_next = DB_HIGH;
          cnt_next      = '0;
          press_pulse   = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      DB_HIGH: begin
        if (!sync_b) begin
          db_state_next = DB_FALL;
          cnt_next      = '0;
        end
      end
      DB_FALL: begin
        if (sync_b) begin
          db_state_next = DB_HIGH;
          cnt_next      = '0;
        end else if (cnt == CNT_LAST) begin
          db_state_next = DB_LOW;
          cnt_next      = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        db_state_next = DB_LOW;
        cnt_next      = '0;
      end
    endcase
  end
`else
  logic sync_prev;
  logic unused_cfg;

  // Timing parameters only matter in the debounced build.
  assign unused_cfg = ^{DEBOUNCE_CYCLES[0], CNT_W[0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_prev <= 1'b0;
    end else begin
      sync_prev <= sync_b;
    end
  end

  assign press_pulse = sync_b & ~sync_prev;
`endif

endmodule

// File: rtl/display_source_latch.sv
// Holds the CPU's last published result and presents one 16-bit half plus the CPU state
// to the hex display; build macro BTN_DEBOUNCE_EN selects the debounced button path.
module display_source_latch
  import display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              result_valid,
  input  logic [31:0]       result,
  input  logic [3:0]        cpu_state,
  input  logic              btn_half,
  output logic [DISP_W-1:0] data,
  output logic [3:0]        state,
  output logic              half_sel,
  output logic              captured
);

  logic [2*DISP_W-1:0] hold;
  logic                press_pulse;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn_debounce (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_half),
    .press_pulse(press_pulse)
  );

  // data is muxed from the registered hold/half_sel, so a capture and a toggle landing on the
  // same edge both show up together one clock later.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold     <= '0;
      captured <= 1'b0;
      half_sel <= 1'b0;
      data     <= '0;
      state    <= '0;
    end else begin
      if (result_valid) begin
        hold     <= result;
        captured <= 1'b1;
      end
      if (press_pulse) begin
        half_sel <= ~half_sel;
      end
      data  <= half_sel ? hold[2*DISP_W-1:DISP_W] : hold[DISP_W-1:0];
      state <= cpu_state;
    end
  end

endmodule

// File: tb/tb_display_source_latch.sv
// Scoreboard bench for display_source_latch with DEBOUNCE_CYCLES=4; expectations adapt to
// whether BTN_DEBOUNCE_EN is defined.
module tb_display_source_latch;

  localparam int DB_CYC = 4;
`ifdef BTN_DEBOUNCE_EN
  localparam int PRESS_LAT = DB_CYC + 3;
`else
  localparam int PRESS_LAT = 3;
`endif

  logic        clk;
  logic        reset;
  logic        result_valid;
  logic [31:0] result;
  logic [3:0]  cpu_state;
  logic        btn_half;
  logic [15:0] data;
  logic [3:0]  state;
  logic        half_sel;
  logic        captured;

  display_source_latch #(
    .DEBOUNCE_CYCLES(DB_CYC),
    .CNT_W          (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .result_valid(result_valid),
    .result      (result),
    .cpu_state   (cpu_state),
    .btn_half    (btn_half),
    .data        (data),
    .state       (state),
    .half_sel    (half_sel),
    .captured    (captured)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        half;
    logic        cap;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_hold = '0;
  logic        model_half = 1'b0;
  logic        model_cap  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp();
    exp_t e;
    e.half = model_half;
    e.cap  = model_cap;
    e.data = model_half ? model_hold[31:16] : model_hold[15:0];
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    check_val({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_val({tag, "_data"}, 32'(data), 32'(e.data));
      check_val({tag, "_half"}, 32'(half_sel), 32'(e.half));
      check_val({tag, "_captured"}, 32'(captured), 32'(e.cap));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    result_valid = 1'b0;
    result       = '0;
    cpu_state    = 4'h5;
    btn_half     = 1'b0;
    tick(2);
    check_val("rst_data", 32'(data), 32'h0);
    check_val("rst_state", 32'(state), 32'h0);
    check_val("rst_half", 32'(half_sel), 32'h0);
    check_val("rst_captured", 32'(captured), 32'h0);
    reset = 1'b0;

    // capture with the lower half selected
    result       = 32'hDEADBEEF;
    result_valid = 1'b1;
    model_hold   = 32'hDEADBEEF;
    model_cap    = 1'b1;
    push_exp();
    tick(1);
    result_valid = 1'b0;
    result       = '0;
    check_val("cap_captured_edge", 32'(captured), 32'h1);
    check_val("cap_data_not_yet", 32'(data), 32'h0);
    tick(1);
    pop_cmp("cap");

    for (int v = 0; v < 4; v++) begin
      cpu_state = 4'(3 * v + 2);
      tick(1);
      check_val("state_follow", 32'(state), 32'(3 * v + 2));
    end

    // long press: one toggle at the expected edge, none while held
    btn_half = 1'b1;
    tick(PRESS_LAT - 1);
    check_val("press_early", 32'(half_sel), 32'h0);
    tick(1);
    check_val("press_edge", 32'(half_sel), 32'h1);
    model_half = 1'b1;
    push_exp();
    tick(10 - PRESS_LAT);
    pop_cmp("press");
    push_exp();
    tick(20);
    pop_cmp("held");
    btn_half = 1'b0;
    tick(12);

    // short 2-clk pulses
    for (int p = 0; p < 3; p++) begin
      btn_half = 1'b1;
      tick(2);
      btn_half = 1'b0;
      tick(10);
`ifndef BTN_DEBOUNCE_EN
      model_half = ~model_half;
`endif
      push_exp();
      pop_cmp("glitch");
    end

    // back-to-back strobes: newest wins
    result       = 32'hAAAA5555;
    result_valid = 1'b1;
    tick(1);
    result       = 32'h0F0F1234;
    tick(1);
    result_valid = 1'b0;
    model_hold   = 32'h0F0F1234;
    push_exp();
    tick(1);
    pop_cmp("b2b");

    if (model_half) begin
      btn_half = 1'b1;
      tick(10);
      btn_half = 1'b0;
      tick(12);
      model_half = 1'b0;
      push_exp();
      pop_cmp("restore_half");
    end

    // capture coinciding with the press pulse
    btn_half = 1'b1;
    tick(PRESS_LAT - 1);
    result       = 32'h12345678;
    result_valid = 1'b1;
    tick(1);
    result_valid = 1'b0;
    result       = '0;
    model_hold   = 32'h12345678;
    model_half   = 1'b1;
    check_val("coinc_half", 32'(half_sel), 32'h1);
    push_exp();
    tick(1);
    pop_cmp("coinc");
    btn_half = 1'b0;
    tick(12);

    // reset in the middle of a debounce count
    cpu_state = 4'h9;
    btn_half  = 1'b1;
    tick(5);
    reset = 1'b1;
    tick(1);
    check_val("mid_rst_data", 32'(data), 32'h0);
    check_val("mid_rst_state", 32'(state), 32'h0);
    check_val("mid_rst_half", 32'(half_sel), 32'h0);
    check_val("mid_rst_captured", 32'(captured), 32'h0);
    reset      = 1'b0;
    btn_half   = 1'b0;
    model_hold = '0;
    model_half = 1'b0;
    model_cap  = 1'b0;
    push_exp();
    tick(15);
    pop_cmp("post_rst");
    check_val("post_rst_state", 32'(state), 32'h9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
